// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// alu_ctrl_pkg : opcodes, FSM state type and default widths for alu_issue_ctrl
// Revision     : 1.0
// ============================================================================
package alu_ctrl_pkg;

   localparam int DEFAULT_DATA_W = 16;

   localparam logic [3:0] OP_LOADI      = 4'h0;
   localparam logic [3:0] OP_READ       = 4'h1;
   localparam logic [3:0] OP_ADD        = 4'h2;
   localparam logic [3:0] OP_SUB        = 4'h3;
   localparam logic [3:0] OP_OR         = 4'h4;
   localparam logic [3:0] OP_XOR        = 4'h5;
   localparam logic [3:0] OP_AND        = 4'h6;
   localparam logic [3:0] OP_NAND       = 4'h7;
   localparam logic [3:0] OP_NOR        = 4'h8;
   localparam logic [3:0] OP_NOT        = 4'h9;
   localparam logic [3:0] OP_LAST_LEGAL = 4'h9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// alu_regfile : NREG x DATA_W registers, two async read ports, one sync write
// Revision    : 1.0
// ============================================================================
module alu_regfile #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs_q [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata_a = regs_q[raddr_a];
   assign rdata_b = regs_q[raddr_b];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// alu_issue_ctrl : one-at-a-time command sequencer in front of the 16-bit ALU
// Revision       : 1.0
// ============================================================================
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int NREG    = 8,
   parameter int ADDR_W  = 3,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_opcode,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_result,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic              busy
);

   localparam logic [3:0] LAT_CNT = 4'(ALU_LAT);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic              resp_err_q, resp_err_d;

   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rf_rdata_a;
   logic [DATA_W-1:0] rf_rdata_b;
   logic              accept;
   logic              is_alu_op;

   // Read ports follow the command fields so operands are sampled at acceptance.
   alu_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata),
      .raddr_a (cmd_rs1),
      .rdata_a (rf_rdata_a),
      .raddr_b (cmd_rs2),
      .rdata_b (rf_rdata_b)
   );

   assign cmd_ready  = rst_n && (state_q == IDLE);
   assign accept     = cmd_valid && cmd_ready;
   assign is_alu_op  = (cmd_opcode >= OP_ADD) && (cmd_opcode <= OP_LAST_LEGAL);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      rd_d        = rd_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      rf_we       = 1'b0;
      rf_waddr    = cmd_rd;
      rf_wdata    = cmd_imm;

      case (state_q)
         IDLE: begin
            if (accept) begin
               rd_d       = cmd_rd;
               resp_err_d = 1'b0;
               if (cmd_opcode == OP_LOADI) begin
                  rf_we       = 1'b1;
                  resp_data_d = cmd_imm;
                  state_d     = RESP;
               end else if (cmd_opcode == OP_READ) begin
                  resp_data_d = rf_rdata_a;
                  state_d     = RESP;
               end else if (is_alu_op) begin
                  alu_a_d  = rf_rdata_a;
                  alu_b_d  = rf_rdata_b;
                  alu_op_d = cmd_opcode;
                  cnt_d    = LAT_CNT;
                  state_d  = EXEC;
               end else begin
                  resp_data_d = '0;
                  resp_err_d  = 1'b1;
                  state_d     = RESP;
               end
            end
         end
         EXEC: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rf_we       = 1'b1;
               rf_waddr    = rd_q;
               rf_wdata    = alu_result;
               resp_data_d = alu_result;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_err_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         rd_q        <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         rd_q        <= rd_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_op_q;
   assign resp_valid = (state_q == RESP);
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_issue_ctrl : directed + random bench with a transaction-level model
// Revision          : 1.0
// ============================================================================
module tb_alu_issue_ctrl;

   localparam int DATA_W  = 16;
   localparam int NREG    = 8;
   localparam int ADDR_W  = 3;
   localparam int ALU_LAT = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [3:0]        cmd_opcode = '0;
   logic [ADDR_W-1:0] cmd_rd = '0;
   logic [ADDR_W-1:0] cmd_rs1 = '0;
   logic [ADDR_W-1:0] cmd_rs2 = '0;
   logic [DATA_W-1:0] cmd_imm = '0;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [3:0]        alu_opcode;
   logic [DATA_W-1:0] alu_result = '0;
   logic              resp_valid;
   logic              resp_ready = 1'b0;
   logic [DATA_W-1:0] resp_data;
   logic              resp_err;
   logic              busy;

   int n_checks = 0;
   int n_err    = 0;

   // Model state
   logic [DATA_W-1:0] m_regs [NREG];
   logic              exp_busy = 1'b0;
   logic              exp_valid = 1'b0;
   logic [DATA_W-1:0] exp_data = '0;
   logic              exp_err = 1'b0;
   logic [DATA_W-1:0] exp_alu_a = '0;
   logic [DATA_W-1:0] exp_alu_b = '0;
   logic [3:0]        exp_alu_op = '0;

   alu_issue_ctrl #(
      .DATA_W  (DATA_W),
      .NREG    (NREG),
      .ADDR_W  (ADDR_W),
      .ALU_LAT (ALU_LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_opcode (cmd_opcode),
      .cmd_rd     (cmd_rd),
      .cmd_rs1    (cmd_rs1),
      .cmd_rs2    (cmd_rs2),
      .cmd_imm    (cmd_imm),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_opcode (alu_opcode),
      .alu_result (alu_result),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] alu_fn(input logic [3:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      case (op)
         4'h2:    return a + b;
         4'h3:    return a - b;
         4'h4:    return a | b;
         4'h5:    return a ^ b;
         4'h6:    return a & b;
         4'h7:    return ~(a & b);
         4'h8:    return ~(a | b);
         4'h9:    return ~a;
         default: return '0;
      endcase
   endfunction

   // Registered ALU: one cycle from alu_* to alu_result.
   always @(posedge clk) alu_result <= alu_fn(alu_opcode, alu_a, alu_b);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("mon_busy", busy, exp_busy);
         chk("mon_cmd_ready", cmd_ready, !exp_busy);
         chk("mon_alu_a", alu_a, exp_alu_a);
         chk("mon_alu_b", alu_b, exp_alu_b);
         chk("mon_alu_op", alu_opcode, exp_alu_op);
         if (resp_valid && exp_valid) begin
            chk("mon_resp_data", resp_data, exp_data);
            chk("mon_resp_err", resp_err, exp_err);
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("cmd_ready_wait", cmd_ready, 1);
   endtask

   task automatic do_cmd(input logic [3:0] op, input logic [ADDR_W-1:0] rd,
                         input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                         input logic [DATA_W-1:0] imm, input int hold,
                         output logic [DATA_W-1:0] got);
      logic [DATA_W-1:0] ed;
      logic              ee;
      bit                is_alu;
      int                lat;
      int                n;
      is_alu = (op >= 4'h2) && (op <= 4'h9);
      ee     = (op > 4'h9);
      if (op == 4'h0)      ed = imm;
      else if (op == 4'h1) ed = m_regs[rs1];
      else if (is_alu)     ed = alu_fn(op, m_regs[rs1], m_regs[rs2]);
      else                 ed = '0;
      lat = is_alu ? ALU_LAT + 2 : 1;

      wait_ready();
      cmd_valid = 1'b1; cmd_opcode = op; cmd_rd = rd;
      cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      exp_busy = 1'b1; exp_valid = 1'b1; exp_data = ed; exp_err = ee;
      if (is_alu) begin
         exp_alu_a  = m_regs[rs1];
         exp_alu_b  = m_regs[rs2];
         exp_alu_op = op;
         chk("issue_alu_op", alu_opcode, op);
         chk("issue_alu_a", alu_a, m_regs[rs1]);
         chk("issue_alu_b", alu_b, m_regs[rs2]);
      end
      if (op == 4'h0)  m_regs[rd] = imm;
      else if (is_alu) m_regs[rd] = ed;

      n = 1;
      while (!resp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, lat);
      chk("resp_data", resp_data, ed);
      chk("resp_err", resp_err, ee);
      got = resp_data;

      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            cmd_valid = 1'b1; cmd_opcode = 4'h0; cmd_rd = rd ^ 3'd1; cmd_imm = 16'hDEAD;
         end
         @(posedge clk); #1;
         chk("hold_valid", resp_valid, 1);
         chk("hold_data", resp_data, ed);
         chk("hold_err", resp_err, ee);
         chk("hold_cmd_ready", cmd_ready, 0);
      end
      cmd_valid = 1'b0;

      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      exp_busy = 1'b0; exp_valid = 1'b0;
      chk("resp_valid_drop", resp_valid, 0);
      chk("resp_err_drop", resp_err, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] got;
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;

      // Reset values while rst_n is held low
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_opcode, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Test 1: LOADI
      do_cmd(4'h0, 3'd1, 3'd0, 3'd0, 16'h1234, 0, got);
      chk("t1_r1", got, 16'h1234);
      do_cmd(4'h0, 3'd2, 3'd0, 3'd0, 16'h0F0F, 0, got);
      chk("t1_r2", got, 16'h0F0F);

      // Test 2: ADD then READ
      do_cmd(4'h2, 3'd3, 3'd1, 3'd2, 16'h0000, 0, got);
      chk("t2_add", got, 16'h2143);
      do_cmd(4'h1, 3'd0, 3'd3, 3'd0, 16'h0000, 0, got);
      chk("t2_read_r3", got, 16'h2143);

      // Test 3: wrap-around SUB and NOT
      do_cmd(4'h0, 3'd4, 3'd0, 3'd0, 16'h0000, 0, got);
      do_cmd(4'h0, 3'd5, 3'd0, 3'd0, 16'h0001, 0, got);
      do_cmd(4'h3, 3'd6, 3'd4, 3'd5, 16'h0000, 0, got);
      chk("t3_sub_wrap", got, 16'hFFFF);
      do_cmd(4'h9, 3'd7, 3'd1, 3'd6, 16'h0000, 0, got);
      chk("t3_not", got, 16'hEDCB);

      // Test 4: backpressure; offered LOADI r2 during hold must be ignored
      do_cmd(4'h2, 3'd3, 3'd1, 3'd2, 16'h0000, 5, got);
      chk("t4_add", got, 16'h2143);
      do_cmd(4'h1, 3'd0, 3'd2, 3'd0, 16'h0000, 0, got);
      chk("t4_r2_untouched", got, 16'h0F0F);
      do_cmd(4'h0, 3'd2, 3'd0, 3'd0, 16'hDEAD, 0, got);
      chk("t4_late_accept", got, 16'hDEAD);

      // Test 5: illegal opcode
      do_cmd(4'hC, 3'd1, 3'd0, 3'd0, 16'h5555, 0, got);
      chk("t5_illegal_data", got, 16'h0000);
      do_cmd(4'h1, 3'd0, 3'd1, 3'd0, 16'h0000, 0, got);
      chk("t5_read_r1", got, 16'h1234);

      // Test 6: reset during EXEC of ADD r3
      do_cmd(4'h0, 3'd3, 3'd0, 3'd0, 16'h7777, 0, got);
      wait_ready();
      cmd_valid = 1'b1; cmd_opcode = 4'h2; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      exp_busy = 1'b1; exp_alu_a = m_regs[1]; exp_alu_b = m_regs[2]; exp_alu_op = 4'h2;
      #1;
      rst_n = 1'b0;
      exp_busy = 1'b0; exp_valid = 1'b0;
      exp_alu_a = '0; exp_alu_b = '0; exp_alu_op = '0;
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      #1;
      chk("t6_resp_valid", resp_valid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_cmd_ready", cmd_ready, 0);
      chk("t6_alu_a", alu_a, 0);
      chk("t6_alu_b", alu_b, 0);
      chk("t6_alu_op", alu_opcode, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_cmd(4'h1, 3'd0, 3'd3, 3'd0, 16'h0000, 0, got);
      chk("t6_read_r3", got, 16'h0000);

      // Random traffic against the model
      for (int k = 0; k < 80; k++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) op = 4'h0;
         do_cmd(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(0, 3)), got);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Command-side initiator for the 16-bit ALU. It accepts register-level commands over a valid/ready handshake and reads operands from an internal register file. It drives opcode and operands to the ALU, waits a configurable latency, captures the result, writes it back, and returns a response over a second valid/ready channel. It is the sequencing front end that sits between the command source (testbench or future decoder) and the ALU datapath.

Parameters:
DATA_W, 16, operand/result width (must match ALU)
NREG, 8, number of general registers
ADDR_W, 3, register address width, equal to clog2(NREG)
ALU_LAT, 1, cycles from alu_* being driven to alu_result being valid; legal range 0..15

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_opcode  in  4  command opcode
cmd_rd  in  ADDR_W  destination register
cmd_rs1  in  ADDR_W  source register A
cmd_rs2  in  ADDR_W  source register B
cmd_imm  in  DATA_W  immediate value for LOADI
alu_a  out  DATA_W  ALU operand A (registered)
alu_b  out  DATA_W  ALU operand B (registered)
alu_opcode  out  4  ALU opcode (registered)
alu_result  in  DATA_W  ALU result
resp_valid  out  1  response present
resp_ready  in  1  response consumer ready
resp_data  out  DATA_W  result or read data
resp_err  out  1  illegal opcode flag
busy  out  1  state is not IDLE

Behaviour:
- Clock port is clk. Reset port is rst_n, asynchronous and active-low.
- Opcodes:
  - 0x0 LOADI: rd <= imm.
  - 0x1 READ: return reg[rs1].
  - 0x2 ADD, 0x3 SUB, 0x4 OR, 0x5 XOR, 0x6 AND, 0x7 NAND, 0x8 NOR, 0x9 NOT(A): issued to the ALU unchanged.
  - 0xA–0xF: illegal.
- Reset values (asynchronous): state IDLE, all registers 0, alu_a/alu_b/alu_opcode 0, resp_valid 0, resp_data 0, resp_err 0, busy 0. cmd_ready is 0 while rst_n is low.
- FSM states: IDLE, EXEC, RESP. cmd_ready = (state==IDLE). Exactly one command is outstanding at a time; there is no pipelining.
- IDLE: the command is accepted on the edge where cmd_valid && cmd_ready.
  - ALU opcode: alu_a <= reg[rs1], alu_b <= reg[rs2], alu_opcode <= opcode, cnt <= ALU_LAT, go to EXEC. Operands are sampled at acceptance, so rd==rs1 is safe.
  - LOADI: reg[rd] <= imm, resp_data <= imm, go to RESP.
  - READ: resp_data <= reg[rs1], go to RESP.
  - Illegal: resp_data <= 0, resp_err <= 1, no writeback, go to RESP.
- EXEC: alu_* are held stable.
  - If cnt != 0, cnt decrements.
  - If cnt == 0, the edge samples alu_result into reg[rd] and resp_data, and the state goes to RESP.
- Latency from the acceptance edge to resp_valid high: ALU ops ALU_LAT+2 cycles (ALU_LAT=1 gives 3); LOADI/READ/illegal 1 cycle.
- RESP: resp_valid=1, with resp_data and resp_err stable until resp_valid && resp_ready. On that edge the state returns to IDLE and resp_valid and resp_err go to 0.
- Writeback happens at capture, independent of resp_ready.
- resp_ready without resp_valid is ignored. cmd_valid outside IDLE is ignored, and the command is not latched.
- alu_* keep their last issued values in IDLE and RESP.
- NOT ignores B, but alu_b is still driven with reg[rs2].
- Arithmetic is performed by the ALU at DATA_W bits with wrap-around. There is no carry or overflow output.
- Register 0 is an ordinary writable register.
- rst_n asserted mid-EXEC or mid-RESP aborts the command: no writeback, all outputs return to reset values immediately, and the register file is cleared.

Decomposition:
- Package alu_ctrl_pkg holds:
  - opcode localparams OP_LOADI..OP_NOT and OP_LAST_LEGAL=4'h9;
  - the state enum typedef (IDLE, EXEC, RESP);
  - the DATA_W default.
- Sub-module alu_regfile: NREG x DATA_W, two combinational read ports, one synchronous write port, asynchronous clear on rst_n.

Test Plan:
1. Reset, then LOADI r1=0x1234 and LOADI r2=0x0F0F -> each gives resp_valid 1 cycle after acceptance with resp_data 0x1234 / 0x0F0F and resp_err 0.
2. With a registered ALU model (ALU_LAT=1), ADD rd=3 rs1=1 rs2=2 -> alu_opcode=2, alu_a=0x1234, alu_b=0x0F0F; resp_data 0x2143 exactly 3 cycles after acceptance; then READ r3 -> 0x2143.
3. LOADI r4=0x0000, LOADI r5=0x0001, SUB r6=r4-r5 -> 0xFFFF (wrap); NOT r7=r1 -> 0xEDCB.
4. Hold resp_ready=0 for 5 cycles after an ADD -> resp_valid, resp_data and resp_err stay stable, cmd_ready=0, and a command offered meanwhile is not accepted; it is accepted after the response handshake.
5. Opcode 0xC with rd=1 -> resp_err=1, resp_data=0; a following READ r1 still returns 0x1234.
6. Assert rst_n low during EXEC of an ADD into r3 -> resp_valid, busy and alu_* are 0 immediately; after release READ r3 returns 0x0000.
